// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory-stage blocks.
//   dmem_state_t : responder FSM states (IDLE, WAIT, DONE)
//   WORD_W       : data word width in bits
//   BYTE_LANES   : byte lanes per word
//   lane_onehot  : byte-enable mask for a single lane
package mips_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_LANES = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } dmem_state_t;

    function automatic logic [BYTE_LANES-1:0] lane_onehot(input logic [1:0] lane);
        logic [BYTE_LANES-1:0] oh;
        oh       = '0;
        oh[lane] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data RAM with an asynchronous read port and a synchronous
// byte-enabled write port sharing one address.
// Ports:
//   clk     : rising-edge clock
//   we_i    : write enable
//   be_i    : byte enables, one bit per lane
//   addr_i  : word index
//   wdata_i : write data (each lane taken from its own byte position)
//   rdata_o : combinational read data at addr_i
module dmem_array
    import mips_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [BYTE_LANES-1:0] be_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [WORD_W-1:0]     wdata_i,
    output logic [WORD_W-1:0]     rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // NOTE: storage arrays get no reset; clearing thousands of words costs a
    // reset fan-out for contents the software never relies on.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (we_i && be_i[i]) begin
                mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data-memory responder: services one load or store per request
// from an internal RAM, stalling the pipeline for LATENCY cycles.
// Optional feature: define DMEM_BYTE_WRITE_EN to enable sbM byte stores.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   memreadM    : load request
//   memwriteM   : store request (wins over memreadM)
//   sbM         : store-byte qualifier (byte-write build only)
//   aluoutM     : byte address
//   writedataM  : store data
//   readdataM   : load data, non-zero only in the completion cycle
//   stallM      : pipeline hold while an access is pending
//   misalignM   : completion-cycle pulse for a misaligned word access
module dmem_responder
    import mips_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memreadM,
    input  logic              memwriteM,
    input  logic              sbM,
    input  logic [WORD_W-1:0] aluoutM,
    input  logic [WORD_W-1:0] writedataM,
    output logic [WORD_W-1:0] readdataM,
    output logic              stallM,
    output logic              misalignM
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic                  req;
    logic                  is_load;
    logic                  byte_st;
    logic                  misaligned;
    logic                  complete;
    logic                  wr_en;
    logic [BYTE_LANES-1:0] wr_be;
    logic [WORD_W-1:0]     wr_data;
    logic [WORD_W-1:0]     rd_data;
    logic                  unused_bits;

    assign req     = memreadM | memwriteM;
    assign is_load = memreadM & ~memwriteM;

`ifdef DMEM_BYTE_WRITE_EN
    assign byte_st     = memwriteM & sbM;
    assign unused_bits = ^aluoutM[WORD_W-1:AW+2];
`else
    assign byte_st     = 1'b0;
    assign unused_bits = ^{aluoutM[WORD_W-1:AW+2], sbM};
`endif

    // Byte stores are exempt from the alignment rule; every other access is a word access.
    assign misaligned = req & ~byte_st & (aluoutM[1:0] != 2'b00);

    // NOTE: every signal written below gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stallM   = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 0) begin
                        complete = 1'b1;
                    end else begin
                        stallM  = 1'b1;
                        cnt_d   = CNT_INIT;
                        state_d = (LATENCY == 1) ? DONE : WAIT;
                    end
                end
            end
            WAIT: begin
                stallM = 1'b1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                complete = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs stay quiet and nothing commits while reset is asserted.
        if (reset) begin
            stallM   = 1'b0;
            complete = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wr_en     = complete & memwriteM & ~misaligned;
    assign wr_be     = byte_st ? lane_onehot(aluoutM[1:0]) : {BYTE_LANES{1'b1}};
    assign wr_data   = byte_st ? {BYTE_LANES{writedataM[7:0]}} : writedataM;
    assign readdataM = (complete & is_load & ~misaligned) ? rd_data : '0;
    assign misalignM = complete & misaligned;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (wr_en),
        .be_i    (wr_be),
        .addr_i  (aluoutM[AW+1:2]),
        .wdata_i (wr_data),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main
// sequence and a LATENCY=0 instance for the zero-wait-state behaviour.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        memreadM, memwriteM, sbM;
    logic [31:0] aluoutM, writedataM;
    logic [31:0] readdataM;
    logic        stallM, misalignM;

    logic        rd0, wr0, sb0;
    logic [31:0] addr0, wdata0;
    logic [31:0] rdata0;
    logic        stall0, mis0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(64), .LATENCY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .memreadM   (memreadM),
        .memwriteM  (memwriteM),
        .sbM        (sbM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .stallM     (stallM),
        .misalignM  (misalignM)
    );

    dmem_responder #(.DEPTH(64), .LATENCY(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .memreadM   (rd0),
        .memwriteM  (wr0),
        .sbM        (sb0),
        .aluoutM    (addr0),
        .writedataM (wdata0),
        .readdataM  (rdata0),
        .stallM     (stall0),
        .misalignM  (mis0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic sb,
                         input logic [31:0] addr, input logic [31:0] data);
        memreadM   = rd;
        memwriteM  = wr;
        sbM        = sb;
        aluoutM    = addr;
        writedataM = data;
    endtask

    // Counts stall cycles until the completion cycle, captures its outputs,
    // then releases the request right after the completing edge.
    task automatic finish_access(output int stalls, output logic [31:0] rdata, output logic mis);
        logic done;
        done   = 1'b0;
        stalls = 0;
        rdata  = '0;
        mis    = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!stallM) begin
                rdata = readdataM;
                mis   = misalignM;
                done  = 1'b1;
            end else begin
                check("stall_rdata_quiet", readdataM, 32'h0);
                check("stall_misalign_quiet", 32'(misalignM), 32'h0);
                stalls++;
            end
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL access_timeout: stallM still high after 40 cycles, required completion");
        end
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic access(input logic rd, input logic wr, input logic sb,
                          input logic [31:0] addr, input logic [31:0] data,
                          output int stalls, output logic [31:0] rdata, output logic mis);
        drive(rd, wr, sb, addr, data);
        finish_access(stalls, rdata, mis);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        logic [31:0] rd;
        logic        ms;
        logic [31:0] exp_byte;
        logic        exp_sb_mis;

`ifdef DMEM_BYTE_WRITE_EN
        exp_byte   = 32'h1122AB44;
        exp_sb_mis = 1'b0;
`else
        exp_byte   = 32'h11223344;
        exp_sb_mis = 1'b1;
`endif

        rd0 = 1'b0; wr0 = 1'b0; sb0 = 1'b0; addr0 = '0; wdata0 = '0;
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset held with a load request pending.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 32'(stallM), 32'h0);
        check("reset_rdata", readdataM, 32'h0);
        check("reset_misalign", 32'(misalignM), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_stall", 32'(stallM), 32'h1);
        finish_access(st, rd, ms);
        check("post_reset_remaining_stalls", 32'(st), 32'd1);

        // Idle with no request.
        @(negedge clk);
        check("idle_stall", 32'(stallM), 32'h0);
        check("idle_rdata", readdataM, 32'h0);
        @(posedge clk);
        #1;

        // Store then load at 0x10, then wrapped alias 0x110.
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, st, rd, ms);
        check("store10_stalls", 32'(st), 32'd2);
        check("store10_rdata", rd, 32'h0);
        check("store10_misalign", 32'(ms), 32'h0);
        access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, st, rd, ms);
        check("load10_stalls", 32'(st), 32'd2);
        check("load10_data", rd, 32'hDEADBEEF);
        access(1'b1, 1'b0, 1'b0, 32'h110, 32'h0, st, rd, ms);
        check("load110_wrap", rd, 32'hDEADBEEF);

        // Misaligned word store is flagged and suppressed.
        access(1'b0, 1'b1, 1'b0, 32'h20, 32'hCAFEF00D, st, rd, ms);
        access(1'b0, 1'b1, 1'b0, 32'h22, 32'h12345678, st, rd, ms);
        check("mis_store_stalls", 32'(st), 32'd2);
        check("mis_store_flag", 32'(ms), 32'h1);
        @(negedge clk);
        check("mis_flag_one_cycle", 32'(misalignM), 32'h0);
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, st, rd, ms);
        check("load20_unchanged", rd, 32'hCAFEF00D);
        check("load20_misalign", 32'(ms), 32'h0);

        // Misaligned load returns zero.
        access(1'b1, 1'b0, 1'b0, 32'h13, 32'h0, st, rd, ms);
        check("mis_load_rdata", rd, 32'h0);
        check("mis_load_flag", 32'(ms), 32'h1);

        // Read and write both high is a store.
        access(1'b1, 1'b1, 1'b0, 32'h14, 32'h55AA55AA, st, rd, ms);
        check("rw_both_rdata", rd, 32'h0);
        check("rw_both_misalign", 32'(ms), 32'h0);
        access(1'b1, 1'b0, 1'b0, 32'h14, 32'h0, st, rd, ms);
        check("rw_both_stored", rd, 32'h55AA55AA);

        // Byte store into lane 1 of word 0x30.
        access(1'b0, 1'b1, 1'b0, 32'h30, 32'h11223344, st, rd, ms);
        access(1'b0, 1'b1, 1'b1, 32'h31, 32'h000000AB, st, rd, ms);
        check("sb_stalls", 32'(st), 32'd2);
        check("sb_misalign", 32'(ms), 32'(exp_sb_mis));
        access(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, st, rd, ms);
        check("sb_load30", rd, exp_byte);

        // Reset during WAIT of a store to 0x40.
        access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0BADF00D, st, rd, ms);
        drive(1'b0, 1'b1, 1'b0, 32'h40, 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("wait_reset_stall", 32'(stallM), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        access(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, st, rd, ms);
        check("wait_reset_idle_stalls", 32'(st), 32'd2);
        check("wait_reset_ram40", rd, 32'h0BADF00D);

        // Reset during DONE of a store to 0x44: no write in the reset cycle.
        access(1'b0, 1'b1, 1'b0, 32'h44, 32'h0000A5A5, st, rd, ms);
        drive(1'b0, 1'b1, 1'b0, 32'h44, 32'hFFFFFFFF);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check("done_reset_stall", 32'(stallM), 32'h0);
        check("done_reset_misalign", 32'(misalignM), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        access(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, st, rd, ms);
        check("done_reset_ram44", rd, 32'h0000A5A5);

        // Zero-latency instance: back-to-back store and load at 0x8.
        wr0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h600DCAFE;
        @(negedge clk);
        check("lat0_store_stall", 32'(stall0), 32'h0);
        check("lat0_store_rdata", rdata0, 32'h0);
        @(posedge clk);
        #1;
        wr0 = 1'b0; rd0 = 1'b1;
        @(negedge clk);
        check("lat0_load_stall", 32'(stall0), 32'h0);
        check("lat0_load_data", rdata0, 32'h600DCAFE);
        @(posedge clk);
        #1;
        addr0 = 32'h9;
        @(negedge clk);
        check("lat0_mis_rdata", rdata0, 32'h0);
        check("lat0_mis_flag", 32'(mis0), 32'h1);
        @(posedge clk);
        #1;
        rd0 = 1'b0; addr0 = 32'h0;
        @(negedge clk);
        check("lat0_idle_rdata", rdata0, 32'h0);
        check("lat0_idle_misalign", 32'(mis0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined MIPS core: the target end of the memory-stage access interface driven by the datapath (address `aluoutM`, store data `writedataM`, load data `readdataM`). It services one load or store per request from an internal word-addressed RAM. It inserts a configurable number of wait states and holds the pipeline with `stallM` until the access completes. It returns full words on loads; byte extraction for `lb` stays in the writeback stage.

## Interface
- `DEPTH`, 64: RAM words; power of two, 4..4096.
- `LATENCY`, 2: stall cycles per access; 0..15.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `memreadM` in 1: load request.
- `memwriteM` in 1: store request; wins over `memreadM` if both are high.
- `sbM` in 1: store-byte qualifier. Used only with `DMEM_BYTE_WRITE_EN`.
- `aluoutM` in 32: byte address.
- `writedataM` in 32: store data.
- `readdataM` out 32: load data. Valid only in the completion cycle, else 0.
- `stallM` out 1: hold the pipeline (the initiator keeps all inputs stable while high).
- `misalignM` out 1: one-cycle pulse in the completion cycle of a misaligned word access.

## Operation
- Request: `memreadM | memwriteM` sampled in IDLE.
- Word index: `aluoutM[$clog2(DEPTH)+1:2]`.
  - Upper address bits are ignored, so addresses wrap modulo 4*DEPTH.
- FSM states: IDLE, WAIT, DONE.
- IDLE, no request: `stallM`=0, `readdataM`=0.
- IDLE, request, `LATENCY`=0:
  - This cycle is the completion cycle.
  - `stallM`=0.
  - Load data is driven combinationally.
  - Store commits at the clock edge.
  - Stay in IDLE.
- IDLE, request, `LATENCY`=N>0:
  - `stallM`=1.
  - `cnt` <= N-1.
  - Next state is DONE if N=1, else WAIT.
- WAIT:
  - `stallM`=1.
  - If `cnt`==1, next state is DONE; else `cnt` <= `cnt`-1.
- DONE (completion cycle):
  - `stallM`=0.
  - `readdataM` = RAM[index] for loads.
  - Store commits at the end of this cycle.
  - Next state is IDLE unconditionally; the following request is seen in IDLE.
- Total stall cycles per access = N exactly. Back-to-back accesses cost N+1 cycles each.
- Both `memreadM` and `memwriteM` high: treated as a store; `readdataM`=0.
- Misaligned access: a word access (load, or store without byte mode) with `aluoutM[1:0]`≠0.
  - Full latency still applies.
  - Store is suppressed.
  - `readdataM`=0.
  - `misalignM`=1 for the completion cycle only.
- Reset values: state IDLE, `cnt`=0, `stallM`=0, `readdataM`=0, `misalignM`=0. RAM contents are not cleared (undefined).
- Reset during WAIT/DONE: return to IDLE and discard the pending store. No RAM write occurs in a reset cycle.

## Timing
- Load data is combinational from RAM in the completion cycle. The datapath registers it into writeback at that edge.
- A store is visible to a load whose completion cycle is later than the store's commit edge; there is no same-cycle bypass.
- `stallM` rises combinationally in the request cycle when N>0, with a path from `memreadM`/`memwriteM` only.
- `misalignM` and `readdataM` are never asserted outside the completion cycle.

## Configuration
- `DMEM_BYTE_WRITE_EN` defined:
  - Store with `sbM`=1 writes `writedataM[7:0]` into byte lane `aluoutM[1:0]` of RAM[index]; other lanes are unchanged.
  - Never flagged misaligned.
  - Latency is the same as a word store.
- Not defined:
  - `sbM` is ignored; the port stays present.
  - All stores are word stores and are subject to the misalignment rule.

## Structure
- Shared package `mips_pkg`:
  - `dmem_state_t` enum (IDLE, WAIT, DONE).
  - `WORD_W`=32.
  - `BYTE_LANES`=4.
- One sub-module, `dmem_array`:
  - DEPTH x 32 RAM.
  - Asynchronous read port.
  - Synchronous write port with 4-bit byte enable.
  - The responder drives byte enable 4'hF for word stores and a one-hot lane for byte stores.

## Test plan
Defaults DEPTH=64, LATENCY=2 unless stated.
- Reset with `memreadM`=1 held -> `stallM`=0, `readdataM`=0, `misalignM`=0 during reset. The first post-reset cycle stalls.
- Store 0xDEADBEEF at 0x10, then load from 0x10 -> each access shows `stallM` high for exactly 2 cycles. The load's DONE cycle returns 0xDEADBEEF.
- Load from 0x110 after the 0x10 store -> returns 0xDEADBEEF (wrap-around).
- Word store 0x12345678 at 0x22 -> `misalignM` pulses 1 cycle. A later load from 0x20 returns the prior contents.
- With `DMEM_BYTE_WRITE_EN`: store 0x11223344 at 0x30, then `sbM` store 0xAB to 0x31 -> load 0x30 returns 0x1122AB44.
- LATENCY=0: back-to-back store/load at 0x8 -> `stallM` never asserted; the load returns the stored value on the next cycle.
- `reset` pulsed while in WAIT of a store to 0x40 -> FSM returns to IDLE; RAM[0x40] is unchanged.
